// File: rtl/demux_select_seq.sv
// Round-robin select sequencer feeding a 1-to-4 demux: grants one channel at a time with a
// fixed enable window followed by an idle gap. Optional stats: DEMUX_SELECT_SEQ_STATS_EN.
module demux_select_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       din,
  output logic       s1,
  output logic       s0,
  output logic       e,
  output logic       i,
  output logic       busy,
  output logic       grant_done
`ifdef DEMUX_SELECT_SEQ_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             req_any;
  logic             eval_idle;
  logic             grant_fire;

  // Protocol: req[n] is a level request with no acknowledge; the grant is visible as
  // e=1 with {s1,s0}=n, and a request not held at an arbitration edge is simply missed.
  always_comb begin
    pick = ptr;
    idx  = ptr;
    // Walk from farthest to nearest so the first set bit after ptr wins.
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
  end

  assign req_any = |req;

  // Arbitration happens in IDLE and also on the final edge of GAP (or HOLD when there is no gap),
  // so a continuously requesting system sees a period of exactly HOLD+GAP cycles.
  assign eval_idle = (state == ST_IDLE) ||
                     (state == ST_GAP  && cnt == '0) ||
                     (state == ST_HOLD && cnt == '0 && GAP_CYCLES == 0);
  assign grant_fire = eval_idle && req_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= 2'd3;
      cnt        <= '0;
      s1         <= 1'b0;
      s0         <= 1'b0;
      e          <= 1'b0;
      i          <= 1'b0;
      busy       <= 1'b0;
      grant_done <= 1'b0;
    end else begin
      i <= din;
      if (eval_idle) begin
        if (req_any) begin
          state      <= ST_HOLD;
          ptr        <= pick;
          {s1, s0}   <= pick;
          cnt        <= HOLD_LOAD;
          e          <= 1'b1;
          busy       <= 1'b1;
          grant_done <= (HOLD_CYCLES == 1);
        end else begin
          state      <= ST_IDLE;
          e          <= 1'b0;
          busy       <= 1'b0;
          grant_done <= 1'b0;
        end
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == '0) begin
              state      <= ST_GAP;
              cnt        <= GAP_LOAD;
              e          <= 1'b0;
              grant_done <= 1'b0;
            end else begin
              cnt        <= cnt - 1'b1;
              grant_done <= (cnt == CNT_W'(1));
            end
          end
          ST_GAP: begin
            cnt <= cnt - 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef DEMUX_SELECT_SEQ_STATS_EN
  // One saturating byte per channel; clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cnt <= '0;
    end else if (grant_fire && stat_cnt[{pick, 3'b000} +: 8] != 8'hff) begin
      stat_cnt[{pick, 3'b000} +: 8] <= stat_cnt[{pick, 3'b000} +: 8] + 8'd1;
    end
  end
`endif

endmodule
